axi_read_arbiter: RTL and testbench

- Arbitrates the single AXI read channel among icache line refill, dcache line refill and dcache uncached word read.
- Sequences each transaction: AR handshake, R beat collection, then a one-cycle completion pulse to the winner.
- Sits between the L1 caches and the AXI master interface, alongside the write path.

---
 rtl/axi_read_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Shares one AXI read channel between three L1 clients: icache line refill,
// dcache line refill and dcache uncached word read. Each transaction runs
// IDLE -> AR -> R -> DONE and ends with a one-cycle done pulse to its owner.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   inst_req_i/addr_i/done_o/rdata_o   icache line client (128-bit line)
//   data_req_i/addr_i/done_o/rdata_o   dcache line client (128-bit line)
//   unc_req_i/addr_i/done_o/rdata_o    uncached word client (32-bit word)
//   err_o                         error of the completing transaction, with done
//   busy_o                        arbiter not idle
//   ar*/r*                        AXI read address / read data channels
module axi_read_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inst_req_i,
    input  logic [31:0]  inst_addr_i,
    output logic         inst_done_o,
    output logic [127:0] inst_rdata_o,
    input  logic         data_req_i,
    input  logic [31:0]  data_addr_i,
    output logic         data_done_o,
    output logic [127:0] data_rdata_o,
    input  logic         unc_req_i,
    input  logic [31:0]  unc_addr_i,
    output logic         unc_done_o,
    output logic [31:0]  unc_rdata_o,
    output logic         err_o,
    output logic         busy_o,
    output logic         arvalid_o,
    input  logic         arready_i,
    output logic [31:0]  araddr_o,
    output logic [7:0]   arlen_o,
    output logic [2:0]   arsize_o,
    input  logic         rvalid_i,
    output logic         rready_o,
    input  logic [31:0]  rdata_i,
    input  logic [1:0]   rresp_i,
    input  logic         rlast_i
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AR   = 2'd1;
    localparam logic [1:0] ST_R    = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] ID_INST = 2'd0;
    localparam logic [1:0] ID_DATA = 2'd1;
    localparam logic [1:0] ID_UNC  = 2'd2;

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [1:0]    state_reg;
    logic [1:0]    winner_reg;
    logic [31:0]   addr_reg;
    logic [7:0]    len_reg;
    logic [1:0]    beat_cnt_reg;
    logic [SW-1:0] starve_cnt_reg;
    logic          rr_reg;       // 1: data was the last line served, inst wins a tie
    logic          err_reg;
    logic [31:0]   unc_rdata_reg;

    // Arbitration
    logic line_pending;
    logic starve_block;
    logic grant_unc;
    logic grant_data;
    logic any_req;

    assign line_pending = inst_req_i | data_req_i;
    assign any_req      = line_pending | unc_req_i;
    // Once the uncached client has taken STARVE_MAX grants in a row over a
    // waiting line client, it yields one grant.
    assign starve_block = line_pending && (starve_cnt_reg == SW'(STARVE_MAX));
    assign grant_unc    = unc_req_i && !starve_block;
    assign grant_data   = !grant_unc && data_req_i && (!inst_req_i || !rr_reg);

    // A beat is in error on a bad response, an rlast before the expected last
    // beat, or a missing rlast at/after the expected last beat.
    logic beat_err;
    logic beat_fire;
    assign beat_fire = (state_reg == ST_R) && rvalid_i;
    assign beat_err  = (rresp_i != 2'b00)
                    || ( rlast_i && ({6'd0, beat_cnt_reg} != len_reg))
                    || (!rlast_i && ({6'd0, beat_cnt_reg} == len_reg));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            winner_reg     <= ID_INST;
            addr_reg       <= '0;
            len_reg        <= '0;
            beat_cnt_reg   <= '0;
            starve_cnt_reg <= '0;
            rr_reg         <= 1'b0;
            err_reg        <= 1'b0;
            unc_rdata_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        state_reg <= ST_AR;
                        if (grant_unc) begin
                            winner_reg <= ID_UNC;
                            addr_reg   <= unc_addr_i;
                            len_reg    <= 8'h0;
                            if (!line_pending)
                                starve_cnt_reg <= '0;
                            else if (starve_cnt_reg != SW'(STARVE_MAX))
                                starve_cnt_reg <= starve_cnt_reg + 1'b1;
                        end else if (grant_data) begin
                            winner_reg     <= ID_DATA;
                            addr_reg       <= {data_addr_i[31:4], 4'b0};
                            len_reg        <= 8'h3;
                            rr_reg         <= 1'b1;
                            starve_cnt_reg <= '0;
                        end else begin
                            winner_reg     <= ID_INST;
                            addr_reg       <= {inst_addr_i[31:4], 4'b0};
                            len_reg        <= 8'h3;
                            rr_reg         <= 1'b0;
                            starve_cnt_reg <= '0;
                        end
                    end
                end
                ST_AR: begin
                    if (arready_i) begin
                        state_reg    <= ST_R;
                        beat_cnt_reg <= '0;
                        err_reg      <= 1'b0;
                    end
                end
                ST_R: begin
                    if (rvalid_i) begin
                        if (winner_reg == ID_UNC)
                            unc_rdata_reg <= rdata_i;
                        // Saturate so excess beats keep landing in the last slice.
                        if (beat_cnt_reg != 2'd3)
                            beat_cnt_reg <= beat_cnt_reg + 2'd1;
                        err_reg <= err_reg | beat_err;
                        if (rlast_i)
                            state_reg <= ST_DONE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Line buffers, one 32-bit word register per slice and client.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            logic [31:0] inst_word_reg;
            logic [31:0] data_word_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    inst_word_reg <= '0;
                    data_word_reg <= '0;
                end else if (beat_fire && (beat_cnt_reg == 2'(gi))) begin
                    if (winner_reg == ID_INST)
                        inst_word_reg <= rdata_i;
                    if (winner_reg == ID_DATA)
                        data_word_reg <= rdata_i;
                end
            end

            assign inst_rdata_o[gi*32 +: 32] = inst_word_reg;
            assign data_rdata_o[gi*32 +: 32] = data_word_reg;
        end
    endgenerate

    assign unc_rdata_o = unc_rdata_reg;
    assign inst_done_o = (state_reg == ST_DONE) && (winner_reg == ID_INST);
    assign data_done_o = (state_reg == ST_DONE) && (winner_reg == ID_DATA);
    assign unc_done_o  = (state_reg == ST_DONE) && (winner_reg == ID_UNC);
    assign err_o       = (state_reg == ST_DONE) && err_reg;
    assign busy_o      = (state_reg != ST_IDLE);
    assign arvalid_o   = (state_reg == ST_AR);
    assign rready_o    = (state_reg == ST_R);
    assign araddr_o    = addr_reg;
    assign arlen_o     = len_reg;
    assign arsize_o    = 3'b010;

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;
    localparam int WHO_INST = 0;
    localparam int WHO_DATA = 1;
    localparam int WHO_UNC  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         inst_req_i, data_req_i, unc_req_i;
    logic [31:0]  inst_addr_i, data_addr_i, unc_addr_i;
    logic         inst_done_o, data_done_o, unc_done_o;
    logic [127:0] inst_rdata_o, data_rdata_o;
    logic [31:0]  unc_rdata_o;
    logic         err_o, busy_o;
    logic         arvalid_o, arready_i;
    logic [31:0]  araddr_o;
    logic [7:0]   arlen_o;
    logic [2:0]   arsize_o;
    logic         rvalid_i, rready_o, rlast_i;
    logic [31:0]  rdata_i;
    logic [1:0]   rresp_i;

    always #5 clk = ~clk;

    axi_read_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
        .inst_done_o(inst_done_o), .inst_rdata_o(inst_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i),
        .data_done_o(data_done_o), .data_rdata_o(data_rdata_o),
        .unc_req_i(unc_req_i), .unc_addr_i(unc_addr_i),
        .unc_done_o(unc_done_o), .unc_rdata_o(unc_rdata_o),
        .err_o(err_o), .busy_o(busy_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
        .rresp_i(rresp_i), .rlast_i(rlast_i)
    );

    typedef struct { int who; logic [127:0] data; logic err; } exp_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct {
        int               ar_delay;
        int               nbeats;
        logic [5:0][31:0] d;
        logic [5:0][1:0]  r;
    } plan_t;

    exp_t  exp_q[$];
    ar_t   ar_q[$];
    plan_t plan_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:4], 4'b0};
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic push_exp(input int who, input logic [127:0] d, input logic e);
        exp_t x;
        x.who = who; x.data = d; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        ar_t x;
        x.addr = a; x.len = l;
        ar_q.push_back(x);
    endtask

    // ---------------- AXI slave model ----------------
    plan_t sp;
    initial begin
        arready_i = 0; rvalid_i = 0; rdata_i = '0; rresp_i = '0; rlast_i = 0;
        forever begin
            @(negedge clk);
            if (arvalid_o && rst) begin
                if (plan_q.size() > 0) begin
                    sp = plan_q.pop_front();
                end else begin
                    // default: immediate ready, beat b carries araddr + b
                    sp.ar_delay = 0;
                    sp.nbeats   = int'(arlen_o) + 1;
                    sp.d = '0; sp.r = '0;
                    for (int b = 0; b < 4; b++) sp.d[b] = araddr_o + 32'(b);
                end
                repeat (sp.ar_delay) @(negedge clk);
                arready_i = 1;
                @(negedge clk);
                arready_i = 0;
                for (int b = 0; b < sp.nbeats; b++) begin
                    rvalid_i = 1;
                    rdata_i  = sp.d[b];
                    rresp_i  = sp.r[b];
                    rlast_i  = (b == sp.nbeats - 1);
                    @(negedge clk);
                end
                rvalid_i = 0; rlast_i = 0; rresp_i = '0; rdata_i = '0;
            end
        end
    end

    // ---------------- Monitor / scoreboard ----------------
    exp_t         mon_e;
    ar_t          mon_a;
    int           mon_n;
    int           mon_who;
    logic [127:0] mon_d;
    always @(negedge clk) begin
        #3;
        if (rst) begin
            mon_n = int'(inst_done_o) + int'(data_done_o) + int'(unc_done_o);
            if (mon_n > 1) begin
                chk("done_onehot", 128'(mon_n), 128'(1));
            end else if (mon_n == 1) begin
                mon_who = inst_done_o ? WHO_INST : (data_done_o ? WHO_DATA : WHO_UNC);
                mon_d   = (mon_who == WHO_INST) ? inst_rdata_o :
                          (mon_who == WHO_DATA) ? data_rdata_o : {96'd0, unc_rdata_o};
                if (exp_q.size() == 0) begin
                    chk("unexpected_done_who", 128'(mon_who), 128'(99));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_owner", 128'(mon_who), 128'(mon_e.who));
                    chk("rdata", mon_d, mon_e.data);
                    chk("err", 128'(err_o), 128'(mon_e.err));
                end
            end
            if (arvalid_o && arready_i) begin
                if (ar_q.size() == 0) begin
                    chk("unexpected_ar_addr", 128'(araddr_o), 128'(0));
                end else begin
                    mon_a = ar_q.pop_front();
                    chk("araddr", 128'(araddr_o), 128'(mon_a.addr));
                    chk("arlen", 128'(arlen_o), 128'(mon_a.len));
                    chk("arsize", 128'(arsize_o), 128'(3'b010));
                end
            end
        end
    end

    // ---------------- Requester ----------------
    function automatic logic done_of(input int who);
        case (who)
            WHO_INST: return inst_done_o;
            WHO_DATA: return data_done_o;
            default:  return unc_done_o;
        endcase
    endfunction

    task automatic set_req(input int who, input logic v, input logic [31:0] a);
        case (who)
            WHO_INST: begin inst_req_i = v; inst_addr_i = a; end
            WHO_DATA: begin data_req_i = v; data_addr_i = a; end
            default:  begin unc_req_i  = v; unc_addr_i  = a; end
        endcase
    endtask

    // Holds the request until n done pulses have been seen, then drops it
    // in the cycle of the last pulse.
    task automatic run_req(input int who, input logic [31:0] a, input int n);
        int got = 0;
        int waited = 0;
        @(negedge clk);
        set_req(who, 1'b1, a);
        while (got < n) begin
            @(negedge clk);
            if (done_of(who)) got++;
            waited++;
            if (waited > 400) begin
                chk("req_timeout_dones", 128'(got), 128'(n));
                break;
            end
        end
        set_req(who, 1'b0, a);
    endtask

    // ---------------- Stimulus ----------------
    plan_t pl;
    int    t0, t1, waited;
    initial begin
        rst = 0;
        inst_req_i = 0; data_req_i = 0; unc_req_i = 0;
        inst_addr_i = '0; data_addr_i = '0; unc_addr_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_arvalid", 128'(arvalid_o), 128'(0));
        chk("rst_rready", 128'(rready_o), 128'(0));
        chk("rst_dones", 128'({inst_done_o, data_done_o, unc_done_o, err_o}), 128'(0));
        chk("rst_rdata", inst_rdata_o | data_rdata_o | {96'd0, unc_rdata_o}, 128'(0));
        chk("rst_araddr", 128'({arlen_o, araddr_o}), 128'(0));
        @(negedge clk);
        rst = 1;

        // Uncached read, arready after 2 cycles
        pl.ar_delay = 2; pl.nbeats = 1; pl.d = '0; pl.r = '0;
        pl.d[0] = 32'hDEADBEEF;
        plan_q.push_back(pl);
        push_ar(32'h1FD0F004, 8'h0);
        push_exp(WHO_UNC, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF, 1'b0);
        run_req(WHO_UNC, 32'h1FD0F004, 1);

        // Icache line, latency check; address changes after grant
        pl.ar_delay = 0; pl.nbeats = 4; pl.d = '0; pl.r = '0;
        pl.d[0] = 32'h11; pl.d[1] = 32'h22; pl.d[2] = 32'h33; pl.d[3] = 32'h44;
        plan_q.push_back(pl);
        push_ar(32'h1C000120, 8'h3);
        push_exp(WHO_INST, 128'h00000044_00000033_00000022_00000011, 1'b0);
        @(negedge clk);
        inst_addr_i = 32'h1C000128; inst_req_i = 1; t0 = cyc;
        @(negedge clk);
        inst_addr_i = 32'hFFFFFFF0;
        waited = 0;
        while (!inst_done_o && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        t1 = cyc;
        inst_req_i = 0;
        chk("inst_latency_cycles", 128'(t1 - t0 + 1), 128'(7));

        // Round-robin: data, inst, data, inst
        push_ar(32'h00001000, 8'h3); push_exp(WHO_DATA, line_of(32'h00001000), 1'b0);
        push_ar(32'h00002000, 8'h3); push_exp(WHO_INST, line_of(32'h00002000), 1'b0);
        push_ar(32'h00001000, 8'h3); push_exp(WHO_DATA, line_of(32'h00001000), 1'b0);
        push_ar(32'h00002000, 8'h3); push_exp(WHO_INST, line_of(32'h00002000), 1'b0);
        fork
            run_req(WHO_DATA, 32'h00001008, 2);
            run_req(WHO_INST, 32'h00002004, 2);
        join

        // Starvation: 4 uncached, 1 data line, then uncached again
        for (int i = 0; i < 4; i++) begin
            push_ar(32'h30000002, 8'h0); push_exp(WHO_UNC, 128'(32'h30000002), 1'b0);
        end
        push_ar(32'h40000010, 8'h3); push_exp(WHO_DATA, line_of(32'h40000010), 1'b0);
        push_ar(32'h30000002, 8'h0); push_exp(WHO_UNC, 128'(32'h30000002), 1'b0);
        fork
            run_req(WHO_UNC, 32'h30000002, 5);
            run_req(WHO_DATA, 32'h40000010, 1);
        join

        // Error: SLVERR on beat 2
        pl.ar_delay = 0; pl.nbeats = 4; pl.d = '0; pl.r = '0;
        pl.d[0] = 32'hA0000000; pl.d[1] = 32'hA0000001;
        pl.d[2] = 32'hA0000002; pl.d[3] = 32'hA0000003;
        pl.r[1] = 2'b10;
        plan_q.push_back(pl);
        push_ar(32'h50000020, 8'h3);
        push_exp(WHO_DATA, 128'hA0000003_A0000002_A0000001_A0000000, 1'b1);
        run_req(WHO_DATA, 32'h50000020, 1);

        // Error: early rlast on beat 2, upper slices keep old data
        pl.ar_delay = 0; pl.nbeats = 2; pl.d = '0; pl.r = '0;
        pl.d[0] = 32'hB0000000; pl.d[1] = 32'hB0000001;
        plan_q.push_back(pl);
        push_ar(32'h50000040, 8'h3);
        push_exp(WHO_DATA, 128'hA0000003_A0000002_B0000001_B0000000, 1'b1);
        run_req(WHO_DATA, 32'h50000040, 1);

        // Error: uncached with excess beats, last one wins the word
        pl.ar_delay = 0; pl.nbeats = 3; pl.d = '0; pl.r = '0;
        pl.d[0] = 32'hC0000000; pl.d[1] = 32'hC0000001; pl.d[2] = 32'hC0000002;
        plan_q.push_back(pl);
        push_ar(32'h60000000, 8'h0);
        push_exp(WHO_UNC, 128'(32'hC0000002), 1'b1);
        run_req(WHO_UNC, 32'h60000000, 1);

        // Clean transaction clears err
        push_ar(32'h60000004, 8'h0);
        push_exp(WHO_UNC, 128'(32'h60000004), 1'b0);
        run_req(WHO_UNC, 32'h60000004, 1);

        // Asynchronous reset mid-burst
        push_ar(32'h70000000, 8'h3);
        @(negedge clk);
        inst_addr_i = 32'h70000000; inst_req_i = 1;
        waited = 0;
        while (!rready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        #1 rst = 0;
        #1;
        chk("arst_arvalid", 128'(arvalid_o), 128'(0));
        chk("arst_rready", 128'(rready_o), 128'(0));
        chk("arst_busy", 128'(busy_o), 128'(0));
        chk("arst_inst_rdata", inst_rdata_o, 128'(0));
        chk("arst_inst_done", 128'(inst_done_o), 128'(0));
        inst_req_i = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        repeat (8) @(negedge clk);
        push_ar(32'h70000100, 8'h3);
        push_exp(WHO_INST, line_of(32'h70000100), 1'b0);
        run_req(WHO_INST, 32'h70000100, 1);

        waited = 0;
        while ((exp_q.size() != 0 || ar_q.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        chk("pending_done_count", 128'(exp_q.size()), 128'(0));
        chk("pending_ar_count", 128'(ar_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
